// File: rtl/lc3_writeback.sv
// lc3_writeback: LC-3 writeback stage. Accepts an execute result through a
// valid/ready handshake into a one-entry stage register, then commits it to
// the 8x16 register file and the NZP condition codes in the following cycle.
// Optional feature macro: LC3_WB_BYPASS_EN forwards the pending stage result
// onto the read ports when the read address matches the pending destination.
module lc3_writeback (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_result,
   input  logic [2:0]  in_dr,
   input  logic        in_ld_reg,
   input  logic        in_ld_cc,
   input  logic        hold,
   input  logic [2:0]  sr1,
   input  logic [2:0]  sr2,
   output logic [15:0] sr1_data,
   output logic [15:0] sr2_data,
   output logic [2:0]  nzp,
   output logic        wb_busy,
   output logic [2:0]  wb_dr,
   output logic        commit
);

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned NREGS  = 8;
   localparam logic [2:0]  NZP_Z  = 3'b010;

   logic [DATA_W-1:0] rf [NREGS];
   logic [DATA_W-1:0] stg_result;
   logic [ADDR_W-1:0] stg_dr;
   logic              stg_valid;
   logic              stg_ld_reg;
   logic              stg_ld_cc;
   logic              accept;

   // Condition codes of a result: exactly one of N, Z, P is set.
   function automatic logic [2:0] cc_of(input logic [DATA_W-1:0] r);
      logic n;
      logic z;
      n = r[DATA_W-1];
      z = (r == DATA_W'(0));
      return {n, z, ~n & ~z};
   endfunction

   // Read port: register file, optionally overridden by the pending entry.
   function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] d;
      d = rf[a];
`ifdef LC3_WB_BYPASS_EN
      if (stg_valid && stg_ld_reg && (a == stg_dr)) d = stg_result;
`endif
      return d;
   endfunction

   assign in_ready = ~hold;
   assign accept   = in_valid & ~hold;

   // Stage register: loads on accept, otherwise drains to empty each edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         stg_valid  <= 1'b0;
         stg_result <= '0;
         stg_dr     <= '0;
         stg_ld_reg <= 1'b0;
         stg_ld_cc  <= 1'b0;
      end else begin
         stg_valid <= accept;
         if (accept) begin
            stg_result <= in_result;
            stg_dr     <= in_dr;
            stg_ld_reg <= in_ld_reg;
            stg_ld_cc  <= in_ld_cc;
         end
      end
   end

   // Commit: retire the pending entry into the register file and NZP.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NREGS); i++) rf[i] <= '0;
         nzp <= NZP_Z;
      end else if (stg_valid) begin
         if (stg_ld_reg) rf[stg_dr] <= stg_result;
         if (stg_ld_cc)  nzp        <= cc_of(stg_result);
      end
   end

   // Status and read ports, all derived from registered state.
   always_comb begin
      commit   = stg_valid;
      wb_busy  = stg_valid & stg_ld_reg;
      wb_dr    = wb_busy ? stg_dr : ADDR_W'(0);
      sr1_data = rd_port(sr1);
      sr2_data = rd_port(sr2);
   end

endmodule

// File: tb/tb_lc3_writeback.sv
// tb_lc3_writeback: directed bench for lc3_writeback; expected values are
// hand-computed. Read-during-commit expectations follow LC3_WB_BYPASS_EN.
module tb_lc3_writeback;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_result;
   logic [2:0]  in_dr;
   logic        in_ld_reg;
   logic        in_ld_cc;
   logic        hold;
   logic [2:0]  sr1;
   logic [2:0]  sr2;
   logic [15:0] sr1_data;
   logic [15:0] sr2_data;
   logic [2:0]  nzp;
   logic        wb_busy;
   logic [2:0]  wb_dr;
   logic        commit;

   int vectors = 0;
   int miscompares = 0;

`ifdef LC3_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   lc3_writeback dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_dr(in_dr), .in_ld_reg(in_ld_reg),
      .in_ld_cc(in_ld_cc), .hold(hold), .sr1(sr1), .sr2(sr2),
      .sr1_data(sr1_data), .sr2_data(sr2_data), .nzp(nzp),
      .wb_busy(wb_busy), .wb_dr(wb_dr), .commit(commit)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] r, input logic [2:0] d,
                        input logic lr, input logic lc);
      in_valid = v; in_result = r; in_dr = d; in_ld_reg = lr; in_ld_cc = lc;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      vectors++; if (nzp !== 3'b010) begin miscompares++; $display("FAIL reset_nzp: got %b exp 010", nzp); end
      vectors++; if (commit !== 1'b0) begin miscompares++; $display("FAIL reset_commit: got %b exp 0", commit); end
      vectors++; if (wb_busy !== 1'b0 || wb_dr !== 3'd0) begin miscompares++; $display("FAIL reset_busy: got %b/%0d exp 0/0", wb_busy, wb_dr); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b exp 1", in_ready); end
      for (int i = 0; i < 8; i++) begin
         sr1 = 3'(i); sr2 = 3'(7 - i); #1;
         vectors++;
         if (sr1_data !== 16'h0 || sr2_data !== 16'h0) begin
            miscompares++; $display("FAIL reset_regs[%0d]: got %h/%h exp 0000/0000", i, sr1_data, sr2_data);
         end
      end
   endtask

   task automatic test_single_cc();
      drive(1'b1, 16'h8001, 3'd3, 1'b1, 1'b1);
      step();
      drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
      sr1 = 3'd3; #1;
      vectors++; if (commit !== 1'b1 || wb_busy !== 1'b1 || wb_dr !== 3'd3) begin miscompares++; $display("FAIL single_commit: got c=%b b=%b dr=%0d exp 1/1/3", commit, wb_busy, wb_dr); end
      vectors++; if (nzp !== 3'b010) begin miscompares++; $display("FAIL single_nzp_old: got %b exp 010", nzp); end
      vectors++; if (sr1_data !== (BYP ? 16'h8001 : 16'h0000)) begin miscompares++; $display("FAIL single_read_commit: got %h exp %h", sr1_data, BYP ? 16'h8001 : 16'h0000); end
      step();
      vectors++; if (commit !== 1'b0 || wb_dr !== 3'd0) begin miscompares++; $display("FAIL single_idle: got c=%b dr=%0d exp 0/0", commit, wb_dr); end
      vectors++; if (sr1_data !== 16'h8001) begin miscompares++; $display("FAIL single_r3: got %h exp 8001", sr1_data); end
      vectors++; if (nzp !== 3'b100) begin miscompares++; $display("FAIL single_nzp: got %b exp 100", nzp); end
   endtask

   task automatic test_back_to_back();
      sr1 = 3'd5;
      drive(1'b1, 16'h0000, 3'd5, 1'b1, 1'b1);
      step();
      drive(1'b1, 16'h0042, 3'd5, 1'b1, 1'b1);
      vectors++; if (commit !== 1'b1 || nzp !== 3'b100) begin miscompares++; $display("FAIL b2b_first: got c=%b nzp=%b exp 1/100", commit, nzp); end
      step();
      drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
      vectors++; if (commit !== 1'b1 || wb_dr !== 3'd5) begin miscompares++; $display("FAIL b2b_second: got c=%b dr=%0d exp 1/5", commit, wb_dr); end
      vectors++; if (nzp !== 3'b010) begin miscompares++; $display("FAIL b2b_nzp_z: got %b exp 010", nzp); end
      vectors++; if (sr1_data !== (BYP ? 16'h0042 : 16'h0000)) begin miscompares++; $display("FAIL b2b_read: got %h exp %h", sr1_data, BYP ? 16'h0042 : 16'h0000); end
      step();
      vectors++; if (commit !== 1'b0) begin miscompares++; $display("FAIL b2b_idle: got %b exp 0", commit); end
      vectors++; if (nzp !== 3'b001) begin miscompares++; $display("FAIL b2b_nzp_p: got %b exp 001", nzp); end
      vectors++; if (sr1_data !== 16'h0042) begin miscompares++; $display("FAIL b2b_r5: got %h exp 0042", sr1_data); end
   endtask

   task automatic test_hold();
      drive(1'b1, 16'h7FFF, 3'd1, 1'b1, 1'b0);
      step();
      hold = 1'b1;
      drive(1'b1, 16'hDEAD, 3'd2, 1'b1, 1'b1);
      #1;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL hold_ready: got %b exp 0", in_ready); end
      vectors++; if (commit !== 1'b1 || wb_dr !== 3'd1) begin miscompares++; $display("FAIL hold_commit_prev: got c=%b dr=%0d exp 1/1", commit, wb_dr); end
      for (int k = 0; k < 2; k++) begin
         step();
         vectors++; if (commit !== 1'b0 || wb_busy !== 1'b0) begin miscompares++; $display("FAIL hold_blocked[%0d]: got c=%b b=%b exp 0/0", k, commit, wb_busy); end
      end
      step();
      hold = 1'b0;
      drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
      sr1 = 3'd1; sr2 = 3'd2; #1;
      vectors++; if (commit !== 1'b0) begin miscompares++; $display("FAIL hold_last: got %b exp 0", commit); end
      vectors++; if (sr1_data !== 16'h7FFF || sr2_data !== 16'h0000) begin miscompares++; $display("FAIL hold_regs: got %h/%h exp 7fff/0000", sr1_data, sr2_data); end
      vectors++; if (nzp !== 3'b001) begin miscompares++; $display("FAIL hold_nzp: got %b exp 001", nzp); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL hold_release: got %b exp 1", in_ready); end
   endtask

   task automatic test_flags();
      drive(1'b1, 16'h9999, 3'd4, 1'b0, 1'b0);
      step();
      drive(1'b1, 16'h5555, 3'd0, 1'b1, 1'b1);
      vectors++; if (commit !== 1'b1 || wb_busy !== 1'b0 || wb_dr !== 3'd0) begin miscompares++; $display("FAIL noop_commit: got c=%b b=%b dr=%0d exp 1/0/0", commit, wb_busy, wb_dr); end
      step();
      drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
      sr1 = 3'd4; sr2 = 3'd0; #1;
      vectors++; if (sr1_data !== 16'h0000 || nzp !== 3'b001) begin miscompares++; $display("FAIL noop_effect: got r4=%h nzp=%b exp 0000/001", sr1_data, nzp); end
      step();
      vectors++; if (sr2_data !== 16'h5555 || nzp !== 3'b001) begin miscompares++; $display("FAIL r0_write: got r0=%h nzp=%b exp 5555/001", sr2_data, nzp); end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 16'h1234, 3'd7, 1'b1, 1'b1);
      step();
      drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
      vectors++; if (commit !== 1'b1 || wb_dr !== 3'd7) begin miscompares++; $display("FAIL rstmid_commit: got c=%b dr=%0d exp 1/7", commit, wb_dr); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      sr1 = 3'd7; #1;
      vectors++; if (sr1_data !== 16'h0000 || nzp !== 3'b010) begin miscompares++; $display("FAIL rstmid_state: got r7=%h nzp=%b exp 0000/010", sr1_data, nzp); end
      vectors++; if (commit !== 1'b0 || wb_busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_stage: got c=%b b=%b exp 0/0", commit, wb_busy); end
   endtask

   task automatic test_read_during_commit();
      drive(1'b1, 16'h00FF, 3'd3, 1'b1, 1'b0);
      step();
      drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
      sr1 = 3'd3; sr2 = 3'd3; #1;
      vectors++; if (sr1_data !== (BYP ? 16'h00FF : 16'h0000)) begin miscompares++; $display("FAIL rdc_sr1: got %h exp %h", sr1_data, BYP ? 16'h00FF : 16'h0000); end
      vectors++; if (sr2_data !== (BYP ? 16'h00FF : 16'h0000)) begin miscompares++; $display("FAIL rdc_sr2: got %h exp %h", sr2_data, BYP ? 16'h00FF : 16'h0000); end
      step();
      vectors++; if (sr1_data !== 16'h00FF || nzp !== 3'b010) begin miscompares++; $display("FAIL rdc_after: got %h nzp=%b exp 00ff/010", sr1_data, nzp); end
   endtask

   initial begin
      reset = 1'b1; hold = 1'b0; sr1 = 3'd0; sr2 = 3'd0;
      drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
      test_reset();
      test_single_cc();
      test_back_to_back();
      test_hold();
      test_flags();
      test_reset_mid();
      test_read_during_commit();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
